// File: rtl/wiscsc15_mem_arb_if.sv
// Bundle of requester-side (fetch/data) and memory-side signals around the arbiter.
// Arbiter uses the slave modport; the requesters and memory model use master.
interface wiscsc15_mem_arb_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        dm_read;
  logic        dm_write;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] if_rdata;
  logic [15:0] dm_rdata;
  logic        if_done;
  logic        dm_done;
  logic        stall;
  logic        err;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, dm_rdata, if_done, dm_done, stall, err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, dm_rdata, if_done, dm_done, stall, err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/wiscsc15_mem_arb.sv
// Single-port memory arbiter between instruction fetch and data accesses, with
// anti-starvation for fetch, a bounded wait for mem_ack and a one-cycle response state.
module wiscsc15_mem_arb #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wiscsc15_mem_arb_if.slave    bus,
  output logic [1:0]           dbg_state_o
);
  // Handshake: requests are levels held until their done pulse; done is a
  // one-cycle pulse with rdata/err valid in that cycle; mem_ack is a one-cycle
  // pulse that is only honoured while a BUSY state holds mem_en high.
  typedef enum logic [1:0] {IDLE, BUSY_DM, BUSY_IF, RESP} state_t;

  state_t      state_q, state_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] dm_rdata_q, dm_rdata_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic        err_q, err_d;
  logic        perr_q, perr_d;
  logic [1:0]  starve_q, starve_d;
  logic [3:0]  wait_q, wait_d;

  logic dm_req;
  logic dm_wins;
  assign dm_req  = bus.dm_read | bus.dm_write;
  assign dm_wins = dm_req & ~(bus.if_req & (starve_q == 2'd3));

  always_comb begin
    state_d     = state_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    err_d       = 1'b0;
    perr_d      = perr_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    case (state_q)
      IDLE: begin
        if (dm_wins) begin
          state_d     = BUSY_DM;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.dm_write;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          perr_d      = bus.dm_read & bus.dm_write;
          wait_d      = 4'd0;
          // dm_wins with if_req pending implies starve_q < 3, so no saturation check needed
          if (bus.if_req) starve_d = starve_q + 2'd1;
        end else if (bus.if_req) begin
          state_d     = BUSY_IF;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = 16'h0000;
          perr_d      = 1'b0;
          wait_d      = 4'd0;
          starve_d    = 2'd0;
        end
      end
      BUSY_DM, BUSY_IF: begin
        if (bus.mem_ack || (wait_q == 4'(TIMEOUT))) begin
          state_d  = RESP;
          mem_en_d = 1'b0;
          if (state_q == BUSY_DM) begin
            dm_done_d = 1'b1;
            err_d     = perr_q | ~bus.mem_ack;
            if (!mem_we_q) dm_rdata_d = bus.mem_ack ? bus.mem_rdata : 16'hFFFF;
          end else begin
            if_done_d  = 1'b1;
            err_d      = ~bus.mem_ack;
            if_rdata_d = bus.mem_ack ? bus.mem_rdata : 16'hFFFF;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      if_rdata_q  <= 16'h0000;
      dm_rdata_q  <= 16'h0000;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      err_q       <= 1'b0;
      perr_q      <= 1'b0;
      starve_q    <= 2'd0;
      wait_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      err_q       <= err_d;
      perr_q      <= perr_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.err       = err_q;
  assign bus.stall     = bus.if_req & ~if_done_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_wiscsc15_mem_arb.sv
// Directed bench for wiscsc15_mem_arb: drivers issue requests and play the memory,
// a negedge monitor checks every done pulse against the expected-response queue.
module tb_wiscsc15_mem_arb;
  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
  wiscsc15_mem_arb_if bus ();

  wiscsc15_mem_arb #(.TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  // entry = {is_dm, err, rdata}
  logic [17:0] exp_q[$];
  logic [15:0] last_dm;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && (bus.if_done || bus.dm_done)) begin
      logic [17:0] e;
      logic [17:0] a;
      a = {bus.dm_done, bus.err, bus.dm_done ? bus.dm_rdata : bus.if_rdata};
      chk("one_done_at_a_time", {30'd0, bus.if_done, bus.dm_done} == 32'd3, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {14'd0, a}, 32'h3ffff);
      end else begin
        e = exp_q.pop_front();
        chk("done_response", {14'd0, a}, {14'd0, e});
      end
    end
  end

  // drivers
  task automatic idle_req();
    bus.if_req = 1'b0; bus.dm_read = 1'b0; bus.dm_write = 1'b0;
  endtask

  // Called at the negedge where a request was just set; returns at the done negedge.
  task automatic serve(input int delay, input logic [15:0] data, input logic [15:0] ea,
                       input logic ewe, input logic [15:0] ewd, input logic chk_wd,
                       input int exp_busy, input string nm);
    int n;
    int busy;
    logic stable;
    n = 0;
    @(negedge clk);
    while (!bus.mem_en && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_grant_lat"}, n, 0);
    if (!bus.mem_en) return;
    chk({nm, "_mem_addr"}, {16'd0, bus.mem_addr}, {16'd0, ea});
    chk({nm, "_mem_we"}, {31'd0, bus.mem_we}, {31'd0, ewe});
    if (chk_wd) chk({nm, "_mem_wdata"}, {16'd0, bus.mem_wdata}, {16'd0, ewd});
    busy = 0;
    stable = 1'b1;
    while (bus.mem_en && busy < 40) begin
      if (bus.mem_addr !== ea || bus.mem_we !== ewe || (chk_wd && bus.mem_wdata !== ewd))
        stable = 1'b0;
      if (busy == delay) begin bus.mem_ack = 1'b1; bus.mem_rdata = data; end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      busy++;
    end
    chk({nm, "_stable"}, {31'd0, stable}, 32'd1);
    chk({nm, "_busy_cycles"}, busy, exp_busy);
  endtask

  initial begin
    logic [15:0] d;
    bit order [8];
    order = '{1, 1, 1, 0, 1, 1, 1, 0};
    rst_n = 1'b0;
    idle_req();
    bus.if_addr = 16'h0; bus.dm_addr = 16'h0; bus.dm_wdata = 16'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
    last_dm = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    chk("rst_if_rdata", {16'd0, bus.if_rdata}, 32'd0);
    chk("rst_dm_rdata", {16'd0, bus.dm_rdata}, 32'd0);
    chk("rst_dones_err", {29'd0, bus.if_done, bus.dm_done, bus.err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single fetch, minimum latency
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    exp_q.push_back({1'b0, 1'b0, 16'hB123});
    #1 chk("stall_while_pending", {31'd0, bus.stall}, 32'd1);
    serve(0, 16'hB123, 16'h0010, 1'b0, 16'h0, 1'b0, 1, "fetch");
    chk("stall_in_done", {31'd0, bus.stall}, 32'd0);
    @(negedge clk); idle_req();

    // store: dm_rdata must not change
    bus.dm_write = 1'b1; bus.dm_addr = 16'h00F0; bus.dm_wdata = 16'h5A5A;
    exp_q.push_back({1'b1, 1'b0, last_dm});
    serve(2, 16'h1234, 16'h00F0, 1'b1, 16'h5A5A, 1'b1, 3, "store");
    @(negedge clk); idle_req();

    // data read
    bus.dm_read = 1'b1; bus.dm_addr = 16'h0044;
    exp_q.push_back({1'b1, 1'b0, 16'hC0DE}); last_dm = 16'hC0DE;
    serve(1, 16'hC0DE, 16'h0044, 1'b0, 16'h0, 1'b0, 2, "load");
    @(negedge clk); idle_req();

    // second store keeps the loaded value
    bus.dm_write = 1'b1; bus.dm_addr = 16'h00F2; bus.dm_wdata = 16'hA5A5;
    exp_q.push_back({1'b1, 1'b0, last_dm});
    serve(0, 16'h9999, 16'h00F2, 1'b1, 16'hA5A5, 1'b1, 1, "store2");
    @(negedge clk); idle_req();

    // contention: both held, expect DM DM DM IF DM DM DM IF
    bus.if_req = 1'b1; bus.if_addr = 16'h1000;
    bus.dm_read = 1'b1; bus.dm_addr = 16'h2000;
    for (int i = 0; i < 8; i++) begin
      d = 16'h3000 + 16'(i);
      exp_q.push_back({order[i], 1'b0, d});
      if (order[i]) last_dm = d;
      serve(0, d, order[i] ? 16'h2000 : 16'h1000, 1'b0, 16'h0, 1'b0, 1,
            $sformatf("contend%0d", i));
      @(negedge clk);
    end
    idle_req();

    // stray mem_ack outside BUSY is ignored
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h7777;
    @(negedge clk); bus.mem_ack = 1'b0;
    chk("stray_ack_mem_en", {31'd0, bus.mem_en}, 32'd0);
    @(negedge clk);
    chk("stray_ack_dm_rdata", {16'd0, bus.dm_rdata}, {16'd0, last_dm});

    // timeout: no ack at all
    bus.dm_read = 1'b1; bus.dm_addr = 16'h0300;
    exp_q.push_back({1'b1, 1'b1, 16'hFFFF}); last_dm = 16'hFFFF;
    serve(-1, 16'h0, 16'h0300, 1'b0, 16'h0, 1'b0, 16, "timeout");
    @(negedge clk); idle_req();

    // ack exactly at wait_cnt == TIMEOUT wins
    bus.dm_read = 1'b1; bus.dm_addr = 16'h0301;
    exp_q.push_back({1'b1, 1'b0, 16'hABCD}); last_dm = 16'hABCD;
    serve(15, 16'hABCD, 16'h0301, 1'b0, 16'h0, 1'b0, 16, "ack_at_limit");
    @(negedge clk); idle_req();

    // protocol error: read and write together performs a write, err on done
    bus.dm_read = 1'b1; bus.dm_write = 1'b1; bus.dm_addr = 16'h0055; bus.dm_wdata = 16'h1111;
    exp_q.push_back({1'b1, 1'b1, last_dm});
    serve(0, 16'h2222, 16'h0055, 1'b1, 16'h1111, 1'b1, 1, "proto_err");
    @(negedge clk); idle_req();

    // reset mid-BUSY aborts without a done
    bus.dm_read = 1'b1; bus.dm_addr = 16'h0066;
    @(negedge clk);
    chk("pre_reset_mem_en", {31'd0, bus.mem_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("reset_drops_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("reset_dm_rdata", {16'd0, bus.dm_rdata}, 32'd0);
    last_dm = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_in_reset", {30'd0, bus.if_done, bus.dm_done}, 32'd0);
    end
    bus.dm_addr = 16'h0077;
    exp_q.push_back({1'b1, 1'b0, 16'h4321});
    rst_n = 1'b1;
    serve(0, 16'h4321, 16'h0077, 1'b0, 16'h0, 1'b0, 1, "after_reset");
    @(negedge clk); idle_req();

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wiscsc15_mem_arb.md
WISCSC15_MEM_ARB -- requirements
Module: wiscsc15_mem_arb

Interface
REQ-001 Ports SHALL use one clock; reset is asynchronous and active-low. Clock port is clk and reset port is rst_n.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 if_req  in  1  fetch read request, level; held until if_done.
REQ-005 if_addr  in  16  fetch word address.
REQ-006 dm_read / dm_write  in  1 each  data request (lw, ret pop / sw, call push), level; held until dm_done.
REQ-007 dm_addr, dm_wdata  in  16 each  data address and store data.
REQ-008 if_rdata, dm_rdata  out  16 each  registered read data; valid in the done cycle; held until the next done.
REQ-009 if_done, dm_done  out  1 each  one-cycle completion pulse.
REQ-010 stall  out  1  if_req & ~if_done, combinational.
REQ-011 err  out  1  valid with a done pulse: timeout or protocol error.
REQ-012 mem_en, mem_we  out  1 each  memory request and write enable.
REQ-013 mem_addr, mem_wdata  out  16 each  registered memory address and write data.
REQ-014 mem_rdata  in  16; mem_ack  in  1  memory read data and completion, one-cycle pulse.
REQ-015 Parameter TIMEOUT, default 15, sets the maximum wait cycles for mem_ack (range 1..15).

Function
REQ-016 The state machine SHALL have states IDLE, BUSY_DM, BUSY_IF and RESP.
REQ-017 IDLE: the block SHALL sample requests. A data request (dm_read|dm_write) wins over if_req unless starve_cnt==3, in which case if_req wins. With no request, it stays in IDLE.
REQ-018 Grant: on the IDLE->BUSY edge, the block SHALL latch address, wdata and we into mem_addr, mem_wdata and mem_we. mem_en SHALL be 1 throughout BUSY_*, and these values SHALL stay stable until exit.
REQ-019 starve_cnt (2-bit, saturating) SHALL increment when IF requested and DM was granted. It SHALL clear on any IF grant.
REQ-020 If dm_read and dm_write are both high at grant, the block SHALL perform a write. It SHALL also flag err=1 on the resulting dm_done.
REQ-021 BUSY_*: wait_cnt (4-bit) SHALL clear on entry and increment each cycle without mem_ack.
REQ-022 A mem_ack in BUSY_* SHALL register mem_rdata into the granted requester's rdata and cause a transition to RESP.
REQ-023 Timeout: if wait_cnt==TIMEOUT with no mem_ack, the block SHALL go to RESP with err=1 and rdata=16'hFFFF.
REQ-024 A mem_ack that arrives in the same cycle as the timeout SHALL win (normal completion, err=0).
REQ-025 RESP (one cycle): the block SHALL hold mem_en=0 and pulse the granted requester's done, then go to IDLE.
REQ-026 Writes SHALL leave dm_rdata unchanged.
REQ-027 The requester SHALL drop or replace its request in the cycle after done. IDLE samples in that cycle, so back-to-back requests cost one IDLE cycle.
REQ-028 Minimum latency from request to done SHALL be 3 cycles: grant edge, ack in the first BUSY cycle, then RESP.
REQ-029 A mem_ack outside BUSY_* SHALL be ignored.
REQ-030 A request deasserted while BUSY SHALL still complete, and done SHALL still pulse.

Reset
REQ-031 When rst_n=0, the block SHALL asynchronously set state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_done=0, dm_done=0, err=0, starve_cnt=0 and wait_cnt=0.
REQ-032 Reset mid-transaction SHALL abort the transaction with no done pulse. The first grant SHALL occur no earlier than the first rising edge after rst_n rises.

Verification
REQ-033 Single fetch: if_req=1, if_addr=16'h0010; mem_ack 1 cycle after mem_en with mem_rdata=16'hB123 -> if_done at cycle 3, if_rdata=16'hB123, err=0, stall low in the done cycle.
REQ-034 Contention: if_req and dm_read both held for 5 transactions -> grant order DM, DM, DM, IF, DM; starve_cnt returns to 0 after the IF grant.
REQ-035 Store: dm_write=1, dm_addr=16'h00F0, dm_wdata=16'h5A5A -> mem_we=1, mem_addr=16'h00F0, mem_wdata=16'h5A5A stable until ack; dm_done pulses; dm_rdata unchanged.
REQ-036 Timeout: dm_read with no mem_ack -> dm_done after TIMEOUT wait cycles, err=1, dm_rdata=16'hFFFF; mem_ack arriving at wait_cnt==TIMEOUT -> err=0 with the real data.
REQ-037 Protocol error: dm_read=dm_write=1 -> write performed (mem_we=1), dm_done with err=1.
REQ-038 Reset mid-BUSY: rst_n low while mem_en=1 -> mem_en drops immediately and no done pulses; the next request completes normally.
